// File: rtl/cnn_pkg.sv
// Shared types and sizing for the CNN image loader.
package cnn_pkg;

    localparam int NUM_PIX = 64;
    localparam int DATA_W  = 32;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, BUSY} bank_state_t;
    typedef enum logic {D_IDLE, D_WAIT} disp_state_t;

endpackage

// File: rtl/cnn_frame_bank.sv
// One frame buffer: single write port, whole frame readable in parallel.
module cnn_frame_bank #(
    parameter int NUM_PIX = cnn_pkg::NUM_PIX,
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int ADDR_W  = $clog2(NUM_PIX)
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               addr,
    input  logic [DATA_W-1:0]               wdata,
    output logic [NUM_PIX-1:0][DATA_W-1:0]  rd_data
);

    always_ff @(posedge clk) begin
        if (we) rd_data[addr] <= wdata;
    end

endmodule

// File: rtl/cnn_img_loader.sv
// Packs a pixel stream into ping-pong frame banks and hands full frames to the CNN core
// one at a time, in arrival order.
module cnn_img_loader #(
    parameter int NUM_PIX = cnn_pkg::NUM_PIX,
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_W-1:0]               s_data,
    input  logic                            s_last,
    output logic [NUM_PIX-1:0][DATA_W-1:0]  img_out,
    output logic                            cnn_enable,
    input  logic                            cnn_done,
    output logic                            frame_err,
    output logic [CNT_W-1:0]                frames_done
);
    import cnn_pkg::*;

    localparam int ADDR_W = $clog2(NUM_PIX);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);

    bank_state_t [1:0]               bank_st, bank_nxt;
    disp_state_t                     disp_st, disp_nxt;
    logic [ADDR_W-1:0]               wr_ptr, wr_ptr_nxt;
    logic                            fill_sel, fill_sel_nxt;
    logic                            run_sel, run_sel_nxt;
    logic                            released;
    logic                            err_nxt;
    logic                            acc, start, finish;
    logic [NUM_PIX-1:0][DATA_W-1:0]  bank_data [2];
    logic [NUM_PIX-1:0][DATA_W-1:0]  img_nxt;

    assign s_ready = !rst && (bank_st[fill_sel] == EMPTY || bank_st[fill_sel] == FILLING);
    assign acc     = s_valid && s_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cnn_frame_bank #(
            .NUM_PIX (NUM_PIX),
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .we      (acc && fill_sel == 1'(b)),
            .addr    (wr_ptr),
            .wdata   (s_data),
            .rd_data (bank_data[b])
        );
    end

    // Dispatcher: 'released' holds off a new start for one cycle after a frame retires.
    assign start  = (disp_st == D_IDLE) && (bank_st[run_sel] == FULL) && !released;
    assign finish = (disp_st == D_WAIT) && cnn_done;

    always_ff @(posedge clk) begin
        if (rst) disp_st <= D_IDLE;
        else     disp_st <= disp_nxt;
    end

    always_comb begin
        disp_nxt = disp_st;
        case (disp_st)
            D_IDLE:  if (start)    disp_nxt = D_WAIT;
            D_WAIT:  if (cnn_done) disp_nxt = D_IDLE;
            default: disp_nxt = D_IDLE;
        endcase
    end

    always_comb begin
        cnn_enable = start && !rst;
    end

    // Fill side touches only EMPTY/FILLING banks, dispatch only FULL/BUSY ones, so the
    // two updates never collide on the same bank.
    always_comb begin
        bank_nxt     = bank_st;
        wr_ptr_nxt   = wr_ptr;
        fill_sel_nxt = fill_sel;
        err_nxt      = 1'b0;
        if (acc) begin
            if (wr_ptr == LAST_IDX) begin
                bank_nxt[fill_sel] = FULL;
                wr_ptr_nxt         = '0;
                fill_sel_nxt       = !fill_sel;
                err_nxt            = !s_last;
            end else if (s_last) begin
                bank_nxt[fill_sel] = EMPTY;
                wr_ptr_nxt         = '0;
                err_nxt            = 1'b1;
            end else begin
                bank_nxt[fill_sel] = FILLING;
                wr_ptr_nxt         = wr_ptr + 1'b1;
            end
        end
        if (start)  bank_nxt[run_sel] = BUSY;
        if (finish) bank_nxt[run_sel] = EMPTY;
    end

    assign run_sel_nxt = finish ? !run_sel : run_sel;

    // Forward the beat being written so a frame completing this cycle is visible with its enable.
    always_comb begin
        img_nxt = bank_data[run_sel_nxt];
        if (acc && fill_sel == run_sel_nxt) img_nxt[wr_ptr] = s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) bank_st[b] <= EMPTY;
            wr_ptr      <= '0;
            fill_sel    <= 1'b0;
            run_sel     <= 1'b0;
            released    <= 1'b0;
            frame_err   <= 1'b0;
            frames_done <= '0;
            img_out     <= '0;
        end else begin
            bank_st     <= bank_nxt;
            wr_ptr      <= wr_ptr_nxt;
            fill_sel    <= fill_sel_nxt;
            run_sel     <= run_sel_nxt;
            released    <= finish;
            frame_err   <= err_nxt;
            frames_done <= frames_done + CNT_W'(finish);
            if (bank_nxt[run_sel_nxt] == FULL) img_out <= img_nxt;
        end
    end

endmodule

// File: tb/tb_cnn_img_loader.sv
// Directed + randomized bench for cnn_img_loader against a frame-queue reference model.
module tb_cnn_img_loader;

    localparam int NP = 64;
    localparam int DW = 32;
    localparam int CW = 16;
    typedef logic [NP-1:0][DW-1:0] img_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    img_t          img_out;
    logic          cnn_enable;
    logic          cnn_done = 1'b0;
    logic          frame_err;
    logic [CW-1:0] frames_done;

    always #5 clk = ~clk;

    cnn_img_loader #(.NUM_PIX(NP), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .img_out     (img_out),
        .cnn_enable  (cnn_enable),
        .cnn_done    (cnn_done),
        .frame_err   (frame_err),
        .frames_done (frames_done)
    );

    int   nchk = 0, npass = 0;
    int   n_en = 0, n_err = 0, stab_bad = 0;
    int   exp_done = 0, exp_err = 0;
    bit   in_flight = 0;
    img_t cur_img;
    img_t exp_q[$], got_q[$];

    // Observer: records every dispatched image and checks it holds while the core works.
    always @(negedge clk) begin
        if (rst) begin
            in_flight = 0;
        end else begin
            if (in_flight && img_out !== cur_img) stab_bad++;
            if (cnn_enable) begin
                n_en++;
                got_q.push_back(img_out);
                cur_img   = img_out;
                in_flight = 1;
            end else if (in_flight && cnn_done) begin
                in_flight = 0;
            end
            if (frame_err) n_err++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_img(input string tag, input img_t got, input img_t exp);
        int idx = 0;
        for (int i = NP - 1; i >= 0; i--) if (got[i] !== exp[i]) idx = i;
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: pixel %0d got %0h expected %0h", tag, idx, got[idx], exp[idx]);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic img_t ramp(input int base);
        img_t f;
        for (int i = 0; i < NP; i++) f[i] = DW'(base + i);
        return f;
    endfunction

    function automatic img_t rnd();
        img_t f;
        for (int i = 0; i < NP; i++) f[i] = $urandom;
        return f;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int k = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
        while (!s_ready && k < 500) begin k++; @(negedge clk); end
        if (k >= 500) chk("beat_timeout", 64'(s_ready), 1);
        step();
    endtask

    task automatic send_img(input img_t f, input int n, input int last_at);
        for (int i = 0; i < n; i++) send_beat(f[i], i == last_at);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_en(input string tag);
        int k = 0;
        @(negedge clk);
        while (!cnn_enable && k < 200) begin k++; @(negedge clk); end
        chk({tag, "_en"}, 64'(cnn_enable), 1);
        step();
    endtask

    task automatic do_done(input string tag);
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        exp_done++;
        @(negedge clk);
        chk({tag, "_frames_done"}, 64'(frames_done), 64'(exp_done));
        chk({tag, "_no_en_after_done"}, 64'(cnn_enable), 0);
        step();
    endtask

    task automatic check_disp(input string tag);
        chk({tag, "_ndisp"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk_img({tag, "_img"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic reset_seq(input string tag);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk({tag, "_rdy_in_rst"}, 64'(s_ready), 0);
        chk({tag, "_en_rst"}, 64'(cnn_enable), 0);
        chk({tag, "_err_rst"}, 64'(frame_err), 0);
        chk({tag, "_fd_rst"}, 64'(frames_done), 0);
        chk_img({tag, "_img_rst"}, img_out, '0);
        step();
        rst = 1'b0;
        exp_done = 0;
        @(negedge clk);
        chk({tag, "_rdy_after"}, 64'(s_ready), 1);
        step();
    endtask

    initial begin
        img_t f, g, a, b, c;
        int   e0;

        // Power-on reset
        step();
        reset_seq("t0");

        // Single ramp frame: enable the cycle after the last beat
        f = ramp(0);
        send_img(f, NP, NP - 1);
        exp_q.push_back(f);
        @(negedge clk);
        chk("t1_en_latency", 64'(cnn_enable), 1);
        chk_img("t1_img", img_out, f);
        step();
        @(negedge clk);
        chk("t1_en_one_cycle", 64'(cnn_enable), 0);
        step();
        do_done("t1");
        check_disp("t1");

        // Three frames with the core busy: third stalls until the first completes
        a = rnd(); b = rnd(); c = rnd();
        send_img(a, NP, NP - 1);
        exp_q.push_back(a);
        wait_en("t2a");
        send_img(b, NP, NP - 1);
        exp_q.push_back(b);
        @(negedge clk);
        chk("t2_backpressure", 64'(s_ready), 0);
        step();
        exp_q.push_back(c);
        fork
            send_img(c, NP, NP - 1);
            begin
                repeat (3) step();
                @(negedge clk);
                chk("t2_stall", 64'(s_ready), 0);
                chk("t2_no_early_en", 64'(n_en), 2);
                step();
                do_done("t2a");
            end
        join
        do_done("t2b");
        wait_en("t2c");
        do_done("t2c");
        check_disp("t2");

        // Early s_last: frame dropped with an error, next frame is clean
        f = rnd();
        send_img(f, 11, 10);
        exp_err++;
        @(negedge clk);
        chk("t3_err", 64'(frame_err), 1);
        chk("t3_no_en", 64'(cnn_enable), 0);
        step();
        @(negedge clk);
        chk("t3_err_pulse", 64'(frame_err), 0);
        step();
        g = ramp(100);
        send_img(g, NP, NP - 1);
        exp_q.push_back(g);
        @(negedge clk);
        chk("t3_en", 64'(cnn_enable), 1);
        chk("t3_pix0", 64'(img_out[0]), 100);
        step();
        do_done("t3");
        check_disp("t3");

        // Missing s_last: error flagged but frame kept; next beat begins a new frame
        f = rnd();
        send_img(f, NP, -1);
        exp_q.push_back(f);
        exp_err++;
        @(negedge clk);
        chk("t4_err", 64'(frame_err), 1);
        chk("t4_en", 64'(cnn_enable), 1);
        step();
        g = rnd();
        send_img(g, NP, NP - 1);
        exp_q.push_back(g);
        do_done("t4a");
        wait_en("t4b");
        do_done("t4b");
        check_disp("t4");
        chk("t4_err_count", 64'(n_err), 64'(exp_err));

        // Reset mid-frame, then mid-WAIT; stray done after reset is ignored
        f = rnd();
        send_img(f, 30, -1);
        reset_seq("t5a");
        check_disp("t5a");
        f = rnd();
        send_img(f, NP, NP - 1);
        exp_q.push_back(f);
        wait_en("t5b");
        check_disp("t5b");
        repeat (2) step();
        reset_seq("t5c");
        e0 = n_en;
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("t5_no_reissue", 64'(n_en), 64'(e0));
        chk("t5_done_ignored", 64'(frames_done), 0);
        step();
        f = rnd();
        send_img(f, NP, NP - 1);
        exp_q.push_back(f);
        wait_en("t5d");
        do_done("t5d");
        check_disp("t5");

        // Done coincides with the final beat of the next frame
        a = rnd(); b = rnd();
        send_img(a, NP, NP - 1);
        exp_q.push_back(a);
        wait_en("t6a");
        send_img(b, NP - 1, -1);
        cnn_done = 1'b1;
        send_beat(b[NP-1], 1'b1);
        cnn_done = 1'b0;
        s_valid = 1'b0; s_last = 1'b0;
        exp_q.push_back(b);
        exp_done++;
        @(negedge clk);
        chk("t6_frames_done", 64'(frames_done), 64'(exp_done));
        step();
        wait_en("t6b");
        do_done("t6b");
        check_disp("t6");

        // Randomized frames with random core turnaround
        for (int r = 0; r < 4; r++) begin
            f = rnd();
            send_img(f, NP, NP - 1);
            exp_q.push_back(f);
            wait_en("rnd");
            repeat ($urandom_range(0, 5)) step();
            do_done("rnd");
        end
        check_disp("rnd");
        chk("img_stable", 64'(stab_bad), 0);
        chk("err_total", 64'(n_err), 64'(exp_err));

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
